// File: rtl/arm_sequencer.sv
// Seven-step pick-rotate-place controller for the two-servo arm.
// Outputs are registered, and each step is held for DWELL_CYC cycles.
module arm_sequencer #(
  parameter int DWELL_CYC = 50_000_000,
  parameter int CW        = $clog2(DWELL_CYC)
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       pause,
  input  logic       abort,
  output logic       sw_0,
  output logic       sw_180,
  output logic       sw_push,
  output logic       sw_pinch,
  output logic       busy,
  output logic       done,
  output logic [2:0] step_idx
);

  typedef enum logic [1:0] {IDLE, RUN, HOMING, DONE} state_t;

  localparam logic [CW-1:0] CNT_LAST  = CW'(DWELL_CYC - 1);
  localparam logic [2:0]    STEP_LAST = 3'd6;
  localparam logic [3:0]    HOME_PAT  = 4'b1000;

  state_t        state_reg, state_next;
  logic [CW-1:0] cnt_reg, cnt_next;
  logic [2:0]    step_reg, step_next;
  logic          done_reg, done_next;
  logic          busy_reg, busy_next;
  logic [3:0]    sw_reg, sw_next;

  // Pattern bits are {sw_0, sw_180, sw_push, sw_pinch}; the gripper stays closed while rotating.
  function automatic logic [3:0] step_pattern(input logic [2:0] s);
    logic [3:0] p;
    case (s)
      3'd0:    p = 4'b1000;
      3'd1:    p = 4'b1010;
      3'd2:    p = 4'b1011;
      3'd3:    p = 4'b1001;
      3'd4:    p = 4'b0101;
      3'd5:    p = 4'b0100;
      default: p = 4'b1000;
    endcase
    return p;
  endfunction

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    step_next  = step_reg;
    done_next  = done_reg;

    if (abort && state_reg != IDLE) begin
      case (state_reg)
        RUN, HOMING: begin
          state_next = HOMING;
          cnt_next   = '0;
          step_next  = 3'd0;
        end
        default: begin
          state_next = IDLE;
          cnt_next   = '0;
          step_next  = 3'd0;
          done_next  = 1'b0;
        end
      endcase
    end else if (start && (state_reg == IDLE || state_reg == DONE)) begin
      state_next = RUN;
      cnt_next   = '0;
      step_next  = 3'd0;
      done_next  = 1'b0;
    end else begin
      case (state_reg)
        RUN: begin
          if (!pause) begin
            if (cnt_reg == CNT_LAST) begin
              cnt_next = '0;
              if (step_reg < STEP_LAST) begin
                step_next = step_reg + 3'd1;
              end else begin
                state_next = DONE;
                step_next  = 3'd0;
                done_next  = 1'b1;
              end
            end else begin
              cnt_next = cnt_reg + CW'(1);
            end
          end
        end
        HOMING: begin
          // The homing dwell deliberately ignores pause.
          if (cnt_reg == CNT_LAST) begin
            state_next = IDLE;
            cnt_next   = '0;
            done_next  = 1'b0;
          end else begin
            cnt_next = cnt_reg + CW'(1);
          end
        end
        default: ;
      endcase
    end

    busy_next = (state_next == RUN) || (state_next == HOMING);
    sw_next   = (state_next == RUN) ? step_pattern(step_next) : HOME_PAT;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
      step_reg  <= 3'd0;
      done_reg  <= 1'b0;
      busy_reg  <= 1'b0;
      sw_reg    <= HOME_PAT;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      step_reg  <= step_next;
      done_reg  <= done_next;
      busy_reg  <= busy_next;
      sw_reg    <= sw_next;
    end
  end

  assign sw_0     = sw_reg[3];
  assign sw_180   = sw_reg[2];
  assign sw_push  = sw_reg[1];
  assign sw_pinch = sw_reg[0];
  assign busy     = busy_reg;
  assign done     = done_reg;
  assign step_idx = step_reg;

endmodule

// File: tb/tb_arm_sequencer.sv
// Scoreboard bench for arm_sequencer: expected observations are queued as stimulus
// is driven and compared one per clock, 1 time unit after each rising edge.
module tb_arm_sequencer;

  localparam int DW = 4;

  logic       clk = 1'b0;
  logic       rst, start, pause, abort;
  logic       sw_0, sw_180, sw_push, sw_pinch, busy, done;
  logic [2:0] step_idx;

  arm_sequencer #(.DWELL_CYC(DW)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .pause    (pause),
    .abort    (abort),
    .sw_0     (sw_0),
    .sw_180   (sw_180),
    .sw_push  (sw_push),
    .sw_pinch (sw_pinch),
    .busy     (busy),
    .done     (done),
    .step_idx (step_idx)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] sw;
    logic       busy;
    logic       done;
    logic [2:0] step;
  } obs_t;

  typedef struct {
    string name;
    obs_t  exp;
  } sb_t;

  typedef struct {
    logic [2:0] step;
    logic [3:0] sw;
  } step_vec_t;

  sb_t       exp_q[$];
  step_vec_t step_tbl[7];
  int        checks = 0;
  int        errors = 0;
  int        cycle  = 0;

  function automatic obs_t mk(input logic [3:0] sw, input logic b, input logic d, input logic [2:0] s);
    obs_t o;
    o.sw   = sw;
    o.busy = b;
    o.done = d;
    o.step = s;
    return o;
  endfunction

  task automatic push(input string name, input obs_t e, input int n);
    sb_t item;
    item.name = name;
    item.exp  = e;
    for (int i = 0; i < n; i++) exp_q.push_back(item);
  endtask

  task automatic push_steps(input string name, input int first, input int last);
    for (int k = first; k <= last; k++)
      push($sformatf("%s_step%0d", name, k), mk(step_tbl[k].sw, 1'b1, 1'b0, step_tbl[k].step), DW);
  endtask

  // One clock: edge, settle, release single-cycle pulses, compare the next expectation.
  task automatic tick();
    sb_t  item;
    obs_t act;
    @(posedge clk);
    #1;
    cycle++;
    start = 1'b0;
    abort = 1'b0;
    if (exp_q.size() > 0) begin
      item = exp_q.pop_front();
      act  = mk({sw_0, sw_180, sw_push, sw_pinch}, busy, done, step_idx);
      checks++;
      if (act !== item.exp) begin
        errors++;
        $display("FAIL %s cyc=%0d got sw=%b busy=%b done=%b step=%0d want sw=%b busy=%b done=%b step=%0d",
                 item.name, cycle, act.sw, act.busy, act.done, act.step,
                 item.exp.sw, item.exp.busy, item.exp.done, item.exp.step);
      end else begin
        $display("cyc=%0d %s sw=%b busy=%b done=%b step=%0d ok", cycle, item.name,
                 act.sw, act.busy, act.done, act.step);
      end
    end
  endtask

  task automatic drain();
    while (exp_q.size() > 0) tick();
  endtask

  obs_t idle_e, done_e;

  initial begin
    step_tbl[0] = '{3'd0, 4'b1000};
    step_tbl[1] = '{3'd1, 4'b1010};
    step_tbl[2] = '{3'd2, 4'b1011};
    step_tbl[3] = '{3'd3, 4'b1001};
    step_tbl[4] = '{3'd4, 4'b0101};
    step_tbl[5] = '{3'd5, 4'b0100};
    step_tbl[6] = '{3'd6, 4'b1000};
    idle_e = mk(4'b1000, 1'b0, 1'b0, 3'd0);
    done_e = mk(4'b1000, 1'b0, 1'b1, 3'd0);

    rst = 1'b0; start = 1'b0; pause = 1'b0; abort = 1'b0;

    // Reset held for two cycles, then released.
    tick();
    push("reset_hold", idle_e, 1);
    tick();
    rst = 1'b1;
    push("reset_release", idle_e, 3);
    drain();

    // Abort while idle is a no-op.
    abort = 1'b1;
    push("abort_idle", idle_e, 3);
    drain();
    while (cycle < 10) tick();

    // Full run, done level held to cycle 100.
    start = 1'b1;
    push_steps("full", 0, 6);
    push("full_done", done_e, 62);
    drain();

    // Pause for 5 cycles inside step 2.
    start = 1'b1;
    push_steps("pause", 0, 1);
    push("pause_step2_pre", mk(step_tbl[2].sw, 1'b1, 1'b0, 3'd2), 2);
    drain();
    pause = 1'b1;
    push("pause_step2_hold", mk(step_tbl[2].sw, 1'b1, 1'b0, 3'd2), 5);
    drain();
    pause = 1'b0;
    push("pause_step2_post", mk(step_tbl[2].sw, 1'b1, 1'b0, 3'd2), 2);
    push_steps("pause", 3, 6);
    push("pause_done", done_e, 3);
    drain();

    // Abort during step 4; pause during homing must not stretch it.
    start = 1'b1;
    push_steps("abort", 0, 3);
    push("abort_step4", mk(step_tbl[4].sw, 1'b1, 1'b0, 3'd4), 2);
    drain();
    abort = 1'b1;
    pause = 1'b1;
    push("abort_homing", mk(4'b1000, 1'b1, 1'b0, 3'd0), DW);
    push("abort_idle_after", idle_e, 3);
    drain();
    pause = 1'b0;

    // Start during step 3 is ignored.
    start = 1'b1;
    push_steps("ign", 0, 2);
    push("ign_step3_a", mk(step_tbl[3].sw, 1'b1, 1'b0, 3'd3), 2);
    drain();
    start = 1'b1;
    push("ign_step3_b", mk(step_tbl[3].sw, 1'b1, 1'b0, 3'd3), 2);
    push_steps("ign", 4, 6);
    push("ign_done", done_e, 3);
    drain();

    // Restart from DONE: done clears immediately and the routine repeats.
    start = 1'b1;
    push_steps("restart", 0, 6);
    push("restart_done", done_e, 3);
    drain();

    // Abort and start together in DONE: abort wins, back to idle.
    abort = 1'b1;
    start = 1'b1;
    push("abort_start_done", idle_e, 3);
    drain();

    // Reset during step 5 returns home on the next edge, no homing dwell.
    start = 1'b1;
    push_steps("rst", 0, 4);
    push("rst_step5", mk(step_tbl[5].sw, 1'b1, 1'b0, 3'd5), 2);
    drain();
    rst = 1'b0;
    push("rst_mid_run", idle_e, 1);
    drain();
    rst = 1'b1;
    push("rst_after", idle_e, 3);
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
